// File: rtl/lc3b_types.sv
// Shared types for the LC-3b memory hierarchy: address and line widths and
// the state encoding of the physical-memory responder.
package lc3b_types;

    typedef logic [15:0]  lc3b_pmem_addr;
    typedef logic [127:0] lc3b_pmem_line;

    // Byte-offset bits within a 16-byte line; the line index starts above them.
    localparam int LINE_OFFSET_W = 4;

    // Width of the latency countdown; LATENCY-1 must fit.
    localparam int LAT_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,   // waiting for a request
        BUSY,   // latency countdown
        RESP,   // pmem_resp high
        GAP     // one mandatory idle cycle after a response
    } pmem_state_t;

endpackage

// File: rtl/pmem_line_array.sv
// Line storage for the responder: synchronous write, registered read.
module pmem_line_array
    import lc3b_types::*;
#(
    parameter int NUM_LINES = 512
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(NUM_LINES)-1:0] index,
    input  lc3b_pmem_line                wdata,
    output lc3b_pmem_line                rdata
);

    lc3b_pmem_line mem [NUM_LINES];

    // Write the addressed line when enabled; register the addressed line every cycle.
    // NOTE: the storage array has no reset; clearing it would turn it into flops.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
        end
        rdata <= mem[index];
    end

endmodule

// File: rtl/pmem_responder.sv
// Physical-memory responder: accepts one line read/write at a time, holds it
// for LATENCY cycles, then completes it with a one-cycle pmem_resp pulse.
module pmem_responder
    import lc3b_types::*;
#(
    parameter int LATENCY   = 4,
    parameter int NUM_LINES = 512
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pmem_read,
    input  logic          pmem_write,
    input  lc3b_pmem_addr pmem_address,
    input  lc3b_pmem_line pmem_wdata,
    output lc3b_pmem_line pmem_rdata,
    output logic          pmem_resp,
    output logic          pmem_error
);

    localparam int                   IDX_W    = $clog2(NUM_LINES);
    localparam logic [LAT_CNT_W-1:0] CNT_INIT = LAT_CNT_W'(LATENCY - 1);

    pmem_state_t          state, state_next;
    logic [LAT_CNT_W-1:0] cnt;
    logic                 op_write;
    logic [IDX_W-1:0]     idx_q;
    lc3b_pmem_line        wdata_q;

    logic                 req;
    logic                 accept;
    logic                 complete;
    logic                 arr_we;
    logic [IDX_W-1:0]     arr_index;
    lc3b_pmem_line        arr_rdata;

    // Offset bits and bits above the index are dropped on purpose (lines alias).
    logic                 unused_addr;
    assign unused_addr = ^pmem_address;

    assign req      = pmem_read | pmem_write;
    assign accept   = (state == IDLE) && req;
    assign complete = (state == BUSY) && req && (cnt == '0);
    assign arr_we   = complete && op_write;

    // In IDLE the array looks at the live address so the registered read is
    // already under way on the acceptance edge; this is what lets LATENCY=1
    // return correct data. Afterwards the latched index is used.
    assign arr_index = (state == IDLE) ? pmem_address[LINE_OFFSET_W +: IDX_W] : idx_q;

    pmem_line_array #(
        .NUM_LINES (NUM_LINES)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .index (arr_index),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: countdown, abort on dropped request, fixed RESP and GAP cycles.
    // NOTE: the default is assigned first so no path leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req) state_next = BUSY;
            BUSY: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (cnt == '0) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch the request at acceptance and run the latency countdown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            op_write <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
        end else if (accept) begin
            cnt      <= CNT_INIT;
            op_write <= pmem_write;
            idx_q    <= pmem_address[LINE_OFFSET_W +: IDX_W];
            wdata_q  <= pmem_wdata;
        end else if (state == BUSY && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Registered outputs: completion pulse, read data on read completion, sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pmem_resp  <= 1'b0;
            pmem_rdata <= '0;
            pmem_error <= 1'b0;
        end else begin
            pmem_resp <= complete;
            if (complete && !op_write) begin
                pmem_rdata <= arr_rdata;
            end
            // Read and write together is a protocol violation; it proceeds as a write.
            if (accept && pmem_read && pmem_write) begin
                pmem_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pmem_responder.sv
// Self-checking bench for pmem_responder: a LATENCY=4 instance for the
// functional scenarios and a LATENCY=1 instance for back-to-back throughput.
module tb_pmem_responder;
    import lc3b_types::*;

    localparam int LAT  = 4;
    localparam int LAT1 = 1;

    localparam lc3b_pmem_line LINE_A  = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    localparam lc3b_pmem_line LINE_B  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    localparam lc3b_pmem_line LINE_C  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam lc3b_pmem_line LINE_D  = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
    localparam lc3b_pmem_line LINE_AA = {16{8'hAA}};
    localparam lc3b_pmem_line LINE_E  = 128'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878;
    localparam lc3b_pmem_line LINE_F  = 128'hCAFE_F00D_1234_5678_9ABC_DEF0_1357_2468;
    localparam lc3b_pmem_line LINE_G  = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;

    logic          clk = 1'b0;
    logic          reset;
    logic          rd, wr;
    lc3b_pmem_addr addr;
    lc3b_pmem_line wdata, rdata;
    logic          resp, err;
    logic          rd1, wr1;
    lc3b_pmem_addr addr1;
    lc3b_pmem_line wdata1, rdata1;
    logic          resp1, err1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int            cyc;
        lc3b_pmem_line data;
        bit            chk;
    } exp_t;

    exp_t sb[$];
    int   sb1[$];

    always #5 clk = ~clk;

    // Count rising edges; expected completion cycles are expressed in this count.
    always @(posedge clk) cyc <= cyc + 1;

    pmem_responder #(.LATENCY(LAT), .NUM_LINES(512)) dut (
        .clk          (clk),
        .reset        (reset),
        .pmem_read    (rd),
        .pmem_write   (wr),
        .pmem_address (addr),
        .pmem_wdata   (wdata),
        .pmem_rdata   (rdata),
        .pmem_resp    (resp),
        .pmem_error   (err)
    );

    pmem_responder #(.LATENCY(LAT1), .NUM_LINES(512)) dut1 (
        .clk          (clk),
        .reset        (reset),
        .pmem_read    (rd1),
        .pmem_write   (wr1),
        .pmem_address (addr1),
        .pmem_wdata   (wdata1),
        .pmem_rdata   (rdata1),
        .pmem_resp    (resp1),
        .pmem_error   (err1)
    );

    task automatic start_req(input logic r, input logic w, input lc3b_pmem_addr a,
                             input lc3b_pmem_line d);
        @(negedge clk);
        rd = r; wr = w; addr = a; wdata = d;
    endtask

    // One complete transaction on the LATENCY=4 instance, scoreboarded.
    // With scr set, address, data and op are disturbed after acceptance.
    task automatic txn(input string name, input logic r, input logic w,
                       input lc3b_pmem_addr a, input lc3b_pmem_line d,
                       input lc3b_pmem_line exp_data, input bit chk, input bit scr);
        exp_t e;
        bit   got;
        start_req(r, w, a, d);
        e.cyc = cyc + 1 + LAT; e.data = exp_data; e.chk = chk;
        sb.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (scr && i == 0) begin
                addr  = a ^ 16'h0100;
                wdata = ~d;
                if (r ^ w) begin rd = w; wr = r; end
            end
            if (resp === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s resp: no pmem_resp within 20 cycles", name);
            sb.delete();
        end else begin
            e = sb.pop_front();
            checks++;
            if (cyc !== e.cyc) begin
                errors++;
                $display("FAIL %s latency: resp at cycle %0d, expected %0d", name, cyc, e.cyc);
            end
            if (e.chk) begin
                checks++;
                if (rdata !== e.data) begin
                    errors++;
                    $display("FAIL %s rdata: got %h expected %h", name, rdata, e.data);
                end
            end
        end
        rd = 1'b0; wr = 1'b0;
        @(negedge clk);
        checks++;
        if (resp !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse width: resp=%b in GAP, expected 0", name, resp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp_v);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rd = 0; wr = 0; addr = '0; wdata = '0;
        rd1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0;
        repeat (3) @(negedge clk);
        check_bit("reset resp", resp, 1'b0);
        check_bit("reset error", err, 1'b0);
        checks++;
        if (rdata !== '0) begin
            errors++;
            $display("FAIL reset rdata: got %h expected 0", rdata);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read;
        // The write must leave pmem_rdata at its reset value.
        txn("wr 1230", 1'b0, 1'b1, 16'h1230, LINE_A, '0, 1'b1, 1'b0);
        txn("rd 123C", 1'b1, 1'b0, 16'h123C, '0, LINE_A, 1'b1, 1'b0);
    endtask

    task automatic test_latched_request;
        txn("wr 0300 scr", 1'b0, 1'b1, 16'h0300, LINE_B, LINE_A, 1'b1, 1'b1);
        txn("rd 0300 scr", 1'b1, 1'b0, 16'h0300, '0, LINE_B, 1'b1, 1'b1);
    endtask

    task automatic test_abort;
        bit seen;
        txn("wr 0400", 1'b0, 1'b1, 16'h0400, LINE_C, LINE_B, 1'b1, 1'b0);
        start_req(1'b0, 1'b1, 16'h0400, LINE_D);
        repeat (2) @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resp === 1'b1) seen = 1'b1;
        end
        check_bit("abort no resp", seen, 1'b0);
        txn("rd 0400 after abort", 1'b1, 1'b0, 16'h0400, '0, LINE_C, 1'b1, 1'b0);
    endtask

    task automatic test_error;
        check_bit("error before", err, 1'b0);
        txn("rw 0800", 1'b1, 1'b1, 16'h0800, LINE_AA, LINE_C, 1'b1, 1'b0);
        check_bit("error set", err, 1'b1);
        txn("rd 0800", 1'b1, 1'b0, 16'h0800, '0, LINE_AA, 1'b1, 1'b0);
        check_bit("error sticky", err, 1'b1);
    endtask

    task automatic test_alias;
        txn("wr 0010", 1'b0, 1'b1, 16'h0010, LINE_E, LINE_AA, 1'b1, 1'b0);
        txn("rd 2010", 1'b1, 1'b0, 16'h2010, '0, LINE_E, 1'b1, 1'b0);
        check_bit("error still sticky", err, 1'b1);
    endtask

    task automatic test_back_to_back;
        int c;
        int pulses;
        @(negedge clk);
        rd1 = 1'b1; addr1 = 16'h0040;
        c = cyc;
        // Held read: accept, 1 BUSY cycle, RESP, GAP, IDLE, re-accept.
        sb1.push_back(c + 2);
        sb1.push_back(c + 6);
        sb1.push_back(c + 10);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (resp1 === 1'b1) begin
                pulses++;
                checks++;
                if (sb1.size() == 0) begin
                    errors++;
                    $display("FAIL b2b extra pulse: resp at cycle %0d, none expected", cyc);
                end else begin
                    int e;
                    e = sb1.pop_front();
                    if (cyc !== e) begin
                        errors++;
                        $display("FAIL b2b pulse time: resp at cycle %0d, expected %0d", cyc, e);
                    end
                end
            end
        end
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL b2b pulse count: got %0d expected 3", pulses);
        end
        sb1.delete();
        rd1 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_busy;
        txn("wr 0500", 1'b0, 1'b1, 16'h0500, LINE_F, LINE_E, 1'b1, 1'b0);
        start_req(1'b0, 1'b1, 16'h0500, LINE_G);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check_bit("async reset resp", resp, 1'b0);
        check_bit("async reset error", err, 1'b0);
        checks++;
        if (rdata !== '0) begin
            errors++;
            $display("FAIL async reset rdata: got %h expected 0", rdata);
        end
        rd = 1'b0; wr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        txn("rd 0500 after reset", 1'b1, 1'b0, 16'h0500, '0, LINE_F, 1'b1, 1'b0);
        check_bit("error after reset", err, 1'b0);
    endtask

    // Sequence the scenarios and report.
    initial begin
        test_reset();
        test_write_read();
        test_latched_request();
        test_abort();
        test_error();
        test_alias();
        test_back_to_back();
        test_reset_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
